ysyx_22050518_pipe_addsub: RTL and testbench

Parametrised, pipelined integer add/subtract unit with valid/ready handshakes on input and output. It splits a WIDTH-bit carry chain into WIDTH/SLICE registered slices. Each slice resolves SLICE bits per cycle, so the execute stage can close timing at 64 bits and wider. It also supports subtract and carry-in chaining, and reports carry, signed overflow and zero flags. It sits between operand dispatch and writeback in the NPC execute path.

---
 rtl/ysyx_22050518_addsub_pkg.sv | 12 +
 rtl/ysyx_22050518_addsub_slice.sv | 12 +
 rtl/ysyx_22050518_pipe_addsub.sv | 106 ++++++++++
 tb/tb_ysyx_22050518_pipe_addsub.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050518_addsub_pkg.sv
// ysyx_22050518_addsub_pkg: op encodings and parameter legality for the add/sub pipe
package ysyx_22050518_addsub_pkg;
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;
  function automatic bit addsub_legal(input int width, input int slice);
    return slice > 0 && width >= slice && width % slice == 0;
  endfunction
endpackage

// File: rtl/ysyx_22050518_addsub_slice.sv
// ysyx_22050518_addsub_slice: combinational SLICE-bit adder with carry in/out
module ysyx_22050518_addsub_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
endmodule

// File: rtl/ysyx_22050518_pipe_addsub.sv
// ysyx_22050518_pipe_addsub: skewed-pipeline add/subtract with valid/ready handshakes
module ysyx_22050518_pipe_addsub
  import ysyx_22050518_addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int STAGES = WIDTH / SLICE;
  logic [STAGES-1:0] v, ld;
  logic [WIDTH-1:0] b_eff;
  logic c0;
  if (!addsub_legal(WIDTH, SLICE)) begin : g_bad
    $error("WIDTH must be a positive multiple of SLICE");
  end
  assign b_eff = (in_op == OP_SUB || in_op == OP_SBC) ? ~in_b : in_b;
  assign c0 = (in_op == OP_ADC || in_op == OP_SBC) ? in_cin : (in_op == OP_SUB);
  assign in_ready = ld[0];
  // Stage k may load when the consumer takes the tail or some stage from k to the tail is empty
  always_comb
    for (int k = 0; k < STAGES; k++) ld[k] = out_ready || (((~v) >> k) != '0);
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int WI = WIDTH - k * SLICE;
    localparam int WS = (k + 1) * SLICE;
    logic [WI-1:0] ai, bi;
    logic [WS-1:0] sn, s_q;
    logic [SLICE-1:0] sl;
    logic ci, vi, co, c_q, v_q;
    if (k == 0) begin : g_head
      assign ai = in_a;
      assign bi = b_eff;
      assign ci = c0;
      assign vi = in_valid;
      assign sn = sl;
    end else begin : g_body
      assign ai = g_st[k-1].g_fw.a_q;
      assign bi = g_st[k-1].g_fw.b_q;
      assign ci = g_st[k-1].c_q;
      assign vi = g_st[k-1].v_q;
      assign sn = {sl, g_st[k-1].s_q};
    end
    ysyx_22050518_addsub_slice #(.SLICE(SLICE)) u_slice (
      .a   (ai[SLICE-1:0]),
      .b   (bi[SLICE-1:0]),
      .cin (ci),
      .sum (sl),
      .cout(co)
    );
    assign v[k] = v_q;
    // Stage valid, low sum bits resolved so far and the carry into the next slice
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (ld[k]) begin
        v_q <= vi;
        if (vi) begin
          s_q <= sn;
          c_q <= co;
        end
      end
    if (k < STAGES - 1) begin : g_fw
      logic [WI-SLICE-1:0] a_q, b_q;
      // Operand slices not yet consumed ride along with their beat
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld[k] && vi) begin
          a_q <= ai[WI-1:SLICE];
          b_q <= bi[WI-1:SLICE];
        end
    end else begin : g_tail
      logic ovf_q, zero_q;
      // Flags are formed as the top slice lands, from operand MSBs and the full sum
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (ld[k] && vi) begin
          ovf_q  <= (ai[WI-1] == bi[WI-1]) && (sl[SLICE-1] != ai[WI-1]);
          zero_q <= ~|sn;
        end
      assign out_valid = v_q;
      assign out_sum   = s_q;
      assign out_cout  = c_q;
      assign out_ovf   = ovf_q;
      assign out_zero  = zero_q;
    end
  end
endmodule

// File: tb/tb_ysyx_22050518_pipe_addsub.sv
// tb_ysyx_22050518_pipe_addsub: random and directed checks against a behavioural queue model
module tb_ysyx_22050518_pipe_addsub;
  import ysyx_22050518_addsub_pkg::*;
  localparam int W = 64;
  localparam int S = 16;
  localparam int ST = W / S;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_cin = 1'b0, out_ready = 1'b1;
  logic [1:0] in_op = 2'b00;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_cout, out_ovf, out_zero;
  logic [W-1:0] out_sum;
  logic [W+2:0] q[$];
  int total = 0, bad = 0, cyc = 0, n_out = 0, first_out = 0, last_out = 0, mode = 0, ph = 0;

  ysyx_22050518_pipe_addsub #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W+2:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W-1:0] bp, s;
    logic c0, co, ov;
    logic signed [W+1:0] wide;
    bp = (op == OP_SUB || op == OP_SBC) ? ~b : b;
    c0 = (op == OP_ADC || op == OP_SBC) ? cin : (op == OP_SUB);
    {co, s} = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, c0};
    wide = $signed({{2{a[W-1]}}, a}) + $signed({{2{bp[W-1]}}, bp}) + $signed({{(W+1){1'b0}}, c0});
    ov = wide != $signed({{2{s[W-1]}}, s});
    return {s, co, ov, s == '0};
  endfunction

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(4))
      0: return '1;
      1: return '0;
      2: return {1'b1, {(W-1){1'b0}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    ph++;
    out_ready = (mode == 0) || (mode == 1 && (ph % 4 == 0 || ph % 4 == 3)) || (mode == 2 && $urandom_range(1) == 1);
  end

  always @(negedge clk)
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        chk("sum", out_sum, q[0][W+2:3]);
        chk("cout", {63'b0, out_cout}, {63'b0, q[0][2]});
        chk("ovf", {63'b0, out_ovf}, {63'b0, q[0][1]});
        chk("zero", {63'b0, out_zero}, {63'b0, q[0][0]});
        if (out_ready) begin
          void'(q.pop_front());
          if (n_out == 0) first_out = cyc;
          last_out = cyc;
          n_out++;
        end
      end
    end

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int t = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_cin = cin;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else q.push_back(model(op, a, b, cin));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] es, input logic ec, input logic eo, input logic ez);
    int n = 1;
    send(op, a, b, cin);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, ST);
    chk("plan_sum", out_sum, es);
    chk("plan_cout", {63'b0, out_cout}, {63'b0, ec});
    chk("plan_ovf", {63'b0, out_ovf}, {63'b0, eo});
    chk("plan_zero", {63'b0, out_zero}, {63'b0, ez});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk("drain", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_valid", {63'b0, out_valid}, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_flags", {61'b0, out_cout, out_ovf, out_zero}, 0);
    chk("rst_ready", {63'b0, in_ready}, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_ready", {63'b0, in_ready}, 1);
    run_one(OP_ADD, '1, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    run_one(OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one(OP_SUB, 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one(OP_ADC, 64'h0000_FFFF, 64'd0, 1'b1, 64'h0001_0000, 1'b0, 1'b0, 1'b0);
    run_one(OP_SBC, 64'd10, 64'd3, 1'b0, 64'd6, 1'b1, 1'b0, 1'b0);
    mode = 1;
    n_out = 0;
    for (int i = 0; i < 8; i++) send(OP_ADD, W'(i), W'(i), 1'b0);
    drain();
    chk("bp_count", n_out, 8);
    mode = 0;
    repeat (2) @(posedge clk);
    #1;
    n_out = 0;
    for (int i = 0; i < 8; i++) send(OP_ADD, W'(i + 100), W'(i), 1'b0);
    drain();
    chk("burst_count", n_out, 8);
    chk("burst_span", last_out - first_out, 7);
    mode = 2;
    for (int i = 0; i < 300; i++)
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end else send(2'($urandom_range(3)), rnd(), rnd(), 1'($urandom_range(1)));
    mode = 0;
    drain();
    mode = 3;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(OP_ADD, W'(i + 7), W'(i), 1'b0);
    for (int t = 0; t < 20 && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    chk("stall_full", {63'b0, out_valid}, 1);
    #2 rst = 1'b1;
    #1;
    chk("flush_valid", {63'b0, out_valid}, 0);
    chk("flush_sum", out_sum, 0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    mode = 0;
    chk("flush_ready", {63'b0, in_ready}, 1);
    n_out = 0;
    run_one(OP_ADD, 64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0, 1'b0);
    drain();
    chk("flush_count", n_out, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end
endmodule
